// File: rtl/eeprom_bram_save.sv
// eeprom_bram_save: 8 KB backup array behind the cartridge EEPROM controller.
// Tracks modifications (dirty) and moves the array sector by sector between
// the byte array and the SD block interface: load on mount, save on request.
module eeprom_bram_save (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] mask,
  input  logic [12:0] eep_addr,
  input  logic [7:0]  eep_d,
  input  logic        eep_wr,
  input  logic        eep_rd,
  output logic [7:0]  eep_q,
  input  logic        img_mounted,
  input  logic        img_size_nz,
  input  logic        img_readonly,
  input  logic        bk_save,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [8:0]  sd_buff_addr,
  input  logic [7:0]  sd_buff_dout,
  output logic [7:0]  sd_buff_din,
  input  logic        sd_buff_wr,
  output logic        dirty,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LD_REQ = 3'd1,
    SV_REQ = 3'd2,
    XFER   = 3'd3,
    NEXT   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  sec_cnt;
  logic        is_load;
  logic        mounted;
  logic        ro;

  // Decoded control strobes from the next-state logic.
  logic        load_start;
  logic        save_start;
  logic        sec_step;
  logic        xfer_done;
  logic        sec_last;

  // Array port controls.
  logic        loading;
  logic        a_we;
  logic        b_we;
  logic [12:0] b_addr;

  // The read strobe is informational (reads are continuous) and the low mask
  // bits only matter to the EEPROM controller's own address masking.
  logic        unused_ok;
  assign unused_ok = &{1'b0, eep_rd, mask[8:0]};

  // Power-up content is all ones, matching an erased EEPROM.
  logic [7:0]  mem [0:8191] = '{default: 8'hFF};

  assign sec_last = (sec_cnt == mask[12:9]);
  assign loading  = is_load && (state_q != IDLE);
  // EEPROM writes are blocked for the whole load so the image cannot be
  // corrupted; this also makes port B the winner of any address collision.
  assign a_we     = eep_wr && !loading;
  assign b_we     = loading && sd_ack && sd_buff_wr;
  assign b_addr   = {sec_cnt, sd_buff_addr};
  assign sd_lba   = {28'd0, sec_cnt};

  // Array write ports: A from the EEPROM side, B from the SD host.
  // NOTE: the array has no reset branch so it maps onto block RAM and keeps its
  // contents across rst_n; only the read registers below are reset.
  always_ff @(posedge clk) begin
    if (a_we) begin
      mem[eep_addr] <= eep_d;
    end
    if (b_we) begin
      mem[b_addr] <= sd_buff_dout;
    end
  end

  // Registered read ports (read-before-write on the same edge).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eep_q       <= 8'h00;
      sd_buff_din <= 8'h00;
    end else begin
      eep_q       <= mem[eep_addr];
      sd_buff_din <= mem[b_addr];
    end
  end

  // State register.
  // NOTE: sequential logic uses non-blocking assignments so every flop samples
  // the values present before the clock edge, independent of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and request/busy outputs.
  // NOTE: every signal assigned here gets a default first so no path through
  // the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    load_start = 1'b0;
    save_start = 1'b0;
    sec_step   = 1'b0;
    xfer_done  = 1'b0;
    sd_rd      = 1'b0;
    sd_wr      = 1'b0;
    busy       = 1'b1;

    case (state_q)
      IDLE: begin
        busy = 1'b0;
        // A mount pulse wins over a save request in the same cycle.
        if (img_mounted) begin
          if (img_size_nz) begin
            state_d    = LD_REQ;
            load_start = 1'b1;
          end
        end else if (bk_save && dirty && mounted && !ro) begin
          state_d    = SV_REQ;
          save_start = 1'b1;
        end
      end
      LD_REQ: begin
        sd_rd = 1'b1;
        if (sd_ack) begin
          state_d = XFER;
        end
      end
      SV_REQ: begin
        sd_wr = 1'b1;
        if (sd_ack) begin
          state_d = XFER;
        end
      end
      XFER: begin
        if (!sd_ack) begin
          state_d = NEXT;
        end
      end
      NEXT: begin
        if (sec_last) begin
          state_d   = IDLE;
          xfer_done = 1'b1;
        end else begin
          sec_step = 1'b1;
          state_d  = is_load ? LD_REQ : SV_REQ;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Mount flags, latched on every mount/unmount pulse. An unmount during a
  // transfer does not abort it; it only inhibits later saves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mounted <= 1'b0;
      ro      <= 1'b0;
    end else if (img_mounted) begin
      mounted <= img_size_nz;
      ro      <= img_readonly;
    end
  end

  // Sector counter and transfer direction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_cnt <= 4'd0;
      is_load <= 1'b0;
    end else begin
      if (xfer_done) begin
        sec_cnt <= 4'd0;
      end else if (sec_step) begin
        sec_cnt <= sec_cnt + 4'd1;
      end
      if (load_start) begin
        is_load <= 1'b1;
      end else if (save_start) begin
        is_load <= 1'b0;
      end
    end
  end

  // Dirty flag: set by any accepted EEPROM write, cleared when a save starts
  // or a load completes. A write in the same cycle as a save start wins so the
  // flag never understates pending modifications.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dirty <= 1'b0;
    end else if (a_we) begin
      dirty <= 1'b1;
    end else if (save_start || (xfer_done && is_load)) begin
      dirty <= 1'b0;
    end
  end

endmodule
